sample_message_printer: RTL and testbench
=========================================

// Module: sample_message_printer
// PURPOSE
//  Sequencer for the 16-entry message ROM (registered, 1-cycle read latency) and the UART transmitter.
//  On each accepted sample byte it emits "Data: 0x" + two hex digits + "\n\r" over the UART.
//  Sits between the level-translator byte sampler (upstream) and the serial_tx block (downstream).
//  Owns the ROM address bus; it is the ROM's only master.
// PARAMETERS
//  PREFIX_LEN   8   ROM entries sent before the hex digits (addr 0..7)
//  MSG_LEN      10  total ROM entries; addr PREFIX_LEN..MSG_LEN-1 are sent after the hex digits
//  HEX_UPPER    1   1: digits A-F; 0: digits a-f
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous reset, active low
//  sample_valid  in   1  one-cycle strobe: sample_data is valid
//  sample_data   in   8  byte to print
//  busy          out  1  high from accept until the last byte's UART transfer completes
//  dropped       out  1  one-cycle pulse: sample_valid arrived while busy
//  rom_addr      out  4  ROM address
//  rom_data      in   8  ROM data, valid the cycle after rom_addr changes
//  tx_data       out  8  byte to the UART
//  new_tx_data   out  1  one-cycle strobe: tx_data is valid
//  tx_busy       in   1  UART busy; goes high the cycle after new_tx_data
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; busy=0, dropped=0, new_tx_data=0, tx_data=8'h00,
//   rom_addr=0, sample register=0, index=0. Reset mid-message aborts; no further strobes are issued.
//  FSM states: IDLE, ROM_RD, ROM_WAIT, SEND, TX_ACK, TX_DONE.
//  IDLE: sample_valid -> latch sample_data, index=0, rom_addr=0, busy=1, go to ROM_RD.
//  ROM_RD: index<PREFIX_LEN or index>=PREFIX_LEN+2 -> rom_addr = ROM index (index, or index-2 after digits),
//   go to ROM_WAIT. index==PREFIX_LEN / PREFIX_LEN+1 -> select hi/lo nibble digit, go to SEND.
//  ROM_WAIT: 1 cycle to cover the ROM latency; capture rom_data as the next byte; go to SEND.
//  SEND: waits while tx_busy=1. When tx_busy=0: drive tx_data, pulse new_tx_data for exactly 1 cycle,
//   go to TX_ACK.
//  TX_ACK: 1-cycle guard so the stale tx_busy=0 is not taken as completion; go to TX_DONE.
//  TX_DONE: waits while tx_busy=1. When tx_busy=0: index+1; if index was MSG_LEN+1 (last of
//   MSG_LEN+2 bytes) -> busy=0, IDLE; else ROM_RD.
//  Hex conversion: nibble 0-9 -> 8'h30+n; 10-15 -> (HEX_UPPER ? 8'h41 : 8'h61)+n-10. Hi nibble first.
//  The index counter is 4 bits wide; MSG_LEN+2 <= 16 is required. It never wraps within one message.
//  Latency from sample_valid to the first new_tx_data is 4 cycles with tx_busy=0 (IDLE,ROM_RD,ROM_WAIT,SEND).
//  sample_valid while busy=1 -> ignored; dropped=1 next cycle. Sample register is not modified.
//  sample_valid in the same cycle busy falls (IDLE entered next cycle) -> dropped; acceptance only in IDLE.
//  tx_busy=1 on entry to SEND (foreign UART user) -> hold in SEND; no strobe until tx_busy=0.
//  Output sequence is fixed at 12 bytes per sample: no early termination except reset.
// STRUCTURE
//  Shared package: FSM state encoding, ASCII constants (8'h30, 8'h41, 8'h61), PREFIX_LEN/MSG_LEN defaults.
//  One sub-module: nibble_to_ascii (combinational, 4-bit in, 8-bit out, HEX_UPPER parameter).
//  ROM and UART remain external instances, wired at top level.
// TESTING (bench models: registered ROM holding the message table; UART with busy for N cycles)
//  sample 8'hA5, UART busy 10 cyc -> bytes "Data: 0xA5\n\r" (12 strobes), busy falls after the last.
//  sample 8'h0F, HEX_UPPER=0 -> hex digits 8'h30,8'h66; 8'h00 -> "00"; 8'hFF -> "FF".
//  sample_valid again at the 3rd byte -> dropped pulses once; output still shows the first sample.
//  tx_busy held high 50 cyc before the first SEND -> no new_tx_data until release, then normal order.
//  rst_n low after the 5th byte -> all outputs at reset values at once; next sample prints in full from "D".
//  tx_busy=0 throughout -> first strobe 4 cyc after sample_valid; at most one strobe per byte.

Source files
------------

// File: rtl/sample_message_printer_pkg.sv
// Shared types/constants for the sample message printer: FSM encoding, ASCII bases, message geometry.
// Pure declarations; no timing or flow control of its own.
package sample_message_printer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ROM_RD   = 3'd1,
    ST_ROM_WAIT = 3'd2,
    ST_SEND     = 3'd3,
    ST_TX_ACK   = 3'd4,
    ST_TX_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  localparam int DEF_PREFIX_LEN = 8;
  localparam int DEF_MSG_LEN    = 10;

  // Message index -> ROM address; the two hex digits occupy indices without a ROM slot.
  function automatic logic [3:0] rom_index(input logic [3:0] idx, input logic [3:0] prefix_len);
    return (idx < prefix_len) ? idx : idx - 4'd2;
  endfunction

endpackage

// File: rtl/sample_message_printer_nibble_to_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit; zero latency, no flow control.
module nibble_to_ascii
  import sample_message_printer_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  logic [7:0] w_alpha_base;

  assign w_alpha_base = HEX_UPPER ? ASCII_UPPER_A : ASCII_LOWER_A;

  always_comb begin
    o_ascii = ASCII_ZERO + {4'b0000, i_nibble};
    if (i_nibble > 4'd9) begin
      o_ascii = w_alpha_base + {4'b0000, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/sample_message_printer.sv
// Prints each accepted sample as "<prefix>HH<suffix>" from the message ROM via the UART; first strobe 4 cycles
// after acceptance, each byte waits for tx_busy low; samples arriving while busy are dropped and flagged.
module sample_message_printer
  import sample_message_printer_pkg::*;
#(
  parameter int PREFIX_LEN = DEF_PREFIX_LEN,
  parameter int MSG_LEN    = DEF_MSG_LEN,
  parameter bit HEX_UPPER  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       busy,
  output logic       dropped,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy
);

  localparam logic [3:0] IDX_PREFIX = 4'(PREFIX_LEN);
  localparam logic [3:0] IDX_HI     = 4'(PREFIX_LEN);
  localparam logic [3:0] IDX_LO     = 4'(PREFIX_LEN + 1);
  localparam logic [3:0] IDX_LAST   = 4'(MSG_LEN + 1);

  state_t     r_state;
  logic [3:0] r_index;
  logic [3:0] r_rom_addr;
  logic [7:0] r_sample;
  logic [7:0] r_byte;
  logic [7:0] r_tx_data;
  logic       r_new_tx;
  logic       r_busy;
  logic       r_dropped;

  state_t     w_state;
  logic [3:0] w_index;
  logic [3:0] w_rom_addr;
  logic [7:0] w_sample;
  logic [7:0] w_byte;
  logic [7:0] w_tx_data;
  logic       w_new_tx;
  logic       w_busy;
  logic       w_dropped;
  logic [3:0] w_index_inc;
  logic       w_cur_is_digit;
  logic       w_inc_is_digit;
  logic [3:0] w_nibble;
  logic [7:0] w_ascii;

  assign w_index_inc    = r_index + 4'd1;
  assign w_cur_is_digit = (r_index == IDX_HI) || (r_index == IDX_LO);
  assign w_inc_is_digit = (w_index_inc == IDX_HI) || (w_index_inc == IDX_LO);
  assign w_nibble       = (r_index == IDX_HI) ? r_sample[7:4] : r_sample[3:0];

  nibble_to_ascii #(
    .HEX_UPPER (HEX_UPPER)
  ) u_nibble_to_ascii (
    .i_nibble (w_nibble),
    .o_ascii  (w_ascii)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_index    <= 4'd0;
      r_rom_addr <= 4'd0;
      r_sample   <= 8'h00;
      r_byte     <= 8'h00;
      r_tx_data  <= 8'h00;
      r_new_tx   <= 1'b0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_index    <= w_index;
      r_rom_addr <= w_rom_addr;
      r_sample   <= w_sample;
      r_byte     <= w_byte;
      r_tx_data  <= w_tx_data;
      r_new_tx   <= w_new_tx;
      r_busy     <= w_busy;
      r_dropped  <= w_dropped;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_index    = r_index;
    w_rom_addr = r_rom_addr;
    w_sample   = r_sample;
    w_byte     = r_byte;
    w_tx_data  = r_tx_data;
    w_new_tx   = 1'b0;
    w_busy     = r_busy;
    w_dropped  = sample_valid && (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (sample_valid) begin
          w_sample   = sample_data;
          w_index    = 4'd0;
          w_rom_addr = 4'd0;
          w_busy     = 1'b1;
          w_state    = ST_ROM_RD;
        end
      end

      ST_ROM_RD: begin
        if (w_cur_is_digit) begin
          w_byte  = w_ascii;
          w_state = ST_SEND;
        end else begin
          w_rom_addr = rom_index(r_index, IDX_PREFIX);
          w_state    = ST_ROM_WAIT;
        end
      end

      ST_ROM_WAIT: begin
        w_byte  = rom_data;
        w_state = ST_SEND;
      end

      ST_SEND: begin
        if (!tx_busy) begin
          w_tx_data = r_byte;
          w_new_tx  = 1'b1;
          w_state   = ST_TX_ACK;
        end
      end

      ST_TX_ACK: begin
        w_state = ST_TX_DONE;
      end

      ST_TX_DONE: begin
        if (!tx_busy) begin
          w_index = w_index_inc;
          if (r_index == IDX_LAST) begin
            w_busy  = 1'b0;
            w_state = ST_IDLE;
          end else begin
            // Address is presented one state early so the registered ROM has data by ROM_WAIT.
            if (!w_inc_is_digit) begin
              w_rom_addr = rom_index(w_index_inc, IDX_PREFIX);
            end
            w_state = ST_ROM_RD;
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign busy        = r_busy;
  assign dropped     = r_dropped;
  assign rom_addr    = r_rom_addr;
  assign tx_data     = r_tx_data;
  assign new_tx_data = r_new_tx;

endmodule

// File: tb/tb_sample_message_printer.sv
// Scoreboard bench: two printers (upper/lower-case hex) with registered-ROM and busy-for-N-cycles UART models.
module tb_sample_message_printer;

  logic       clk;
  logic       rst_n;
  logic       sv      [2];
  logic [7:0] sd      [2];
  logic       busy    [2];
  logic       dropped [2];
  logic [3:0] addr    [2];
  logic [7:0] rdat    [2];
  logic [7:0] txd     [2];
  logic       ntx     [2];
  logic       txb     [2];
  logic       hold    [2];
  int         ucnt    [2];
  int         n_strobe[2];
  int         n_drop  [2];
  bit         prev_ntx[2];
  int         uart_cyc;
  int         n_chk;
  int         n_err;
  logic [7:0] rom [16];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  sample_message_printer #(.PREFIX_LEN(8), .MSG_LEN(10), .HEX_UPPER(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv[0]), .sample_data(sd[0]),
    .busy(busy[0]), .dropped(dropped[0]), .rom_addr(addr[0]), .rom_data(rdat[0]),
    .tx_data(txd[0]), .new_tx_data(ntx[0]), .tx_busy(txb[0])
  );

  sample_message_printer #(.PREFIX_LEN(8), .MSG_LEN(10), .HEX_UPPER(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv[1]), .sample_data(sd[1]),
    .busy(busy[1]), .dropped(dropped[1]), .rom_addr(addr[1]), .rom_data(rdat[1]),
    .tx_data(txd[1]), .new_tx_data(ntx[1]), .tx_busy(txb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h44; rom[1] = 8'h61; rom[2] = 8'h74; rom[3] = 8'h61;
    rom[4] = 8'h3A; rom[5] = 8'h20; rom[6] = 8'h30; rom[7] = 8'h78;
    rom[8] = 8'h0A; rom[9] = 8'h0D;
  end

  always @(posedge clk) begin
    rdat[0] <= rom[addr[0]];
    rdat[1] <= rom[addr[1]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ntx[k]) ucnt[k] <= uart_cyc;
      else if (ucnt[k] != 0) ucnt[k] <= ucnt[k] - 1;
    end
  end

  assign txb[0] = (ucnt[0] != 0) || hold[0];
  assign txb[1] = (ucnt[1] != 0) || hold[1];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] qpop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic qpush(input int k, input logic [7:0] b);
    if (k == 0) exp_q0.push_back(b);
    else exp_q1.push_back(b);
  endtask

  task automatic push_msg(input int k, input logic [7:0] d);
    string pre;
    pre = "Data: 0x";
    for (int i = 0; i < 8; i++) qpush(k, pre[i]);
    qpush(k, hexc(d[7:4], k == 0));
    qpush(k, hexc(d[3:0], k == 0));
    qpush(k, 8'h0A);
    qpush(k, 8'h0D);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ntx[k]) begin
        int sz;
        n_strobe[k]++;
        check_val($sformatf("strobe_gap%0d", k), {31'd0, prev_ntx[k]}, 0);
        check_val($sformatf("txbusy_at_strobe%0d", k), {31'd0, txb[k]}, 0);
        sz = qsize(k);
        check_val($sformatf("sb_has_entry%0d", k), {31'd0, sz != 0}, 1);
        if (sz != 0) check_val($sformatf("tx_byte%0d", k), {24'd0, txd[k]}, {24'd0, qpop(k)});
      end
      if (dropped[k]) n_drop[k]++;
      prev_ntx[k] = ntx[k];
    end
  end

  task automatic send(input int k, input logic [7:0] d);
    @(posedge clk); #1;
    sv[k] = 1'b1;
    sd[k] = d;
    push_msg(k, d);
    @(posedge clk); #1;
    sv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (busy[k] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_val($sformatf("idle_timeout%0d", k), {31'd0, busy[k]}, 0);
    check_val($sformatf("sb_drained%0d", k), qsize(k), 0);
  endtask

  task automatic wait_strobes(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (n_strobe[k] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("strobe_reach", {31'd0, n_strobe[k] >= target}, 1);
  endtask

  task automatic check_reset(input int k);
    check_val($sformatf("rst_busy%0d", k), {31'd0, busy[k]}, 0);
    check_val($sformatf("rst_dropped%0d", k), {31'd0, dropped[k]}, 0);
    check_val($sformatf("rst_new_tx%0d", k), {31'd0, ntx[k]}, 0);
    check_val($sformatf("rst_tx_data%0d", k), {24'd0, txd[k]}, 0);
    check_val($sformatf("rst_rom_addr%0d", k), {28'd0, addr[k]}, 0);
  endtask

  initial begin
    int base;
    int dbase;
    int lat;
    n_chk = 0; n_err = 0; uart_cyc = 10;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; sd[k] = 8'h00; hold[k] = 1'b0;
      ucnt[k] = 0; n_strobe[k] = 0; n_drop[k] = 0; prev_ntx[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;

    // Full message with a slow UART; busy must outlast the final transfer.
    base = n_strobe[0];
    send(0, 8'hA5);
    wait_idle(0, 2000);
    check_val("a5_count", n_strobe[0] - base, 12);
    check_val("uart_idle_at_busy_fall", {31'd0, txb[0]}, 0);

    base = n_strobe[1];
    send(1, 8'h0F);
    wait_idle(1, 2000);
    check_val("lower_count", n_strobe[1] - base, 12);

    send(0, 8'h00);
    wait_idle(0, 2000);
    send(0, 8'hFF);
    wait_idle(0, 2000);

    // Second sample during the third byte is dropped, output unchanged.
    base = n_strobe[0];
    dbase = n_drop[0];
    send(0, 8'h3C);
    wait_strobes(0, base + 3, 1000);
    @(posedge clk); #1;
    sv[0] = 1'b1; sd[0] = 8'h99;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    check_val("dropped_pulse", {31'd0, dropped[0]}, 1);
    wait_idle(0, 2000);
    check_val("drop_count", n_drop[0] - dbase, 1);

    // Foreign UART user holds tx_busy before the first send.
    hold[0] = 1'b1;
    base = n_strobe[0];
    send(0, 8'h5A);
    repeat (50) @(posedge clk);
    #1;
    check_val("hold_no_strobe", n_strobe[0] - base, 0);
    check_val("hold_busy", {31'd0, busy[0]}, 1);
    hold[0] = 1'b0;
    wait_idle(0, 2000);
    check_val("hold_count", n_strobe[0] - base, 12);

    // Reset mid-message.
    base = n_strobe[0];
    send(0, 8'h12);
    wait_strobes(0, base + 5, 1000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    exp_q0.delete();
    base = n_strobe[0];
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_no_strobe", n_strobe[0] - base, 0);
    rst_n = 1'b1;
    send(0, 8'h7E);
    wait_idle(0, 2000);
    check_val("post_rst_count", n_strobe[0] - base, 12);

    // Zero-latency UART: first strobe exactly 4 cycles after the sample cycle.
    uart_cyc = 0;
    repeat (15) @(posedge clk);
    base = n_strobe[0];
    @(posedge clk); #1;
    sv[0] = 1'b1; sd[0] = 8'hC3;
    push_msg(0, 8'hC3);
    lat = 0;
    do begin
      @(posedge clk); #1;
      sv[0] = 1'b0;
      lat++;
    end while (!ntx[0] && lat < 20);
    check_val("latency", lat, 4);
    wait_idle(0, 2000);
    check_val("fast_count", n_strobe[0] - base, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1);
  end

endmodule
